// File: rtl/misalign_access_unit.sv
// misalign_access_unit
//   Sits between the MEM stage and a byte-addressable data memory. Aligned
//   loads/stores pass straight through in the same cycle. Misaligned half/word
//   accesses are split into a sequence of byte accesses while the pipeline is
//   stalled. Loads are reassembled and sign/zero extended before being returned.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous, active-low reset
//   req_valid           MEM stage presents an access this cycle
//   req_read/req_write  load / store request
//   req_func3           RISC-V load/store funct3
//   req_addr/req_wdata  byte address / store data
//   mem_rdata           combinational read data from the data memory
//   mem_addr/mem_wdata  address / write data to the data memory
//   mem_read/mem_write  memory access strobes
//   mem_func3           access size/extension code to the data memory
//   load_data           final load result to MEM/WB
//   load_valid          load_data is valid this cycle
//   stall               freeze the pipeline
//   illegal             one-cycle pulse for an unsupported request
module misalign_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  mem_func3,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        stall,
  output logic        illegal
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPLIT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [1:0]          cnt;
  logic [DATA_W-1:0]   asm_word;
  logic [31:0]         addr_p1;
  logic [DATA_W-1:0]   wdata_p1;
  logic [2:0]          func3_p1;
  logic                read_p1;
  logic                write_p1;
  logic                req_bad;
  logic                req_aligned;
  logic                start;
  logic                last_byte;

  // Sign- or zero-extend the reassembled word according to the load funct3.
  function automatic logic [DATA_W-1:0] extend_load(input logic [2:0] f3,
                                                    input logic [DATA_W-1:0] word);
    logic signed [15:0]       half_s;
    logic signed [DATA_W-1:0] half_ext;
    half_s   = signed'(word[15:0]);
    half_ext = DATA_W'(half_s);
    case (f3)
      3'b001:  extend_load = half_ext;
      3'b101:  extend_load = {16'h0000, word[15:0]};
      default: extend_load = word;
    endcase
  endfunction

  always_comb begin
    req_bad = (req_func3 == 3'b011) || (req_func3 == 3'b110) ||
              (req_func3 == 3'b111) || (req_read && req_write);
    req_aligned = 1'b0;
    case (req_func3[1:0])
      2'b00:   req_aligned = 1'b1;
      2'b01:   req_aligned = ~req_addr[0];
      2'b10:   req_aligned = (req_addr[1:0] == 2'b00);
      default: req_aligned = 1'b0;
    endcase
    // Only half (x01) and word (010) can reach SPLIT, so func3[1:0] picks N.
    last_byte = (func3_p1[1:0] == 2'b01) ? (cnt == 2'd1) : (cnt == 2'd3);
  end

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_func3  = 3'b000;
    load_data  = 32'h0;
    load_valid = 1'b0;
    stall      = 1'b0;
    illegal    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            illegal = 1'b1;
          end else if (!req_aligned && (req_read || req_write)) begin
            stall     = 1'b1;
            start     = 1'b1;
            state_nxt = SPLIT;
          end else begin
            mem_addr   = req_addr;
            mem_wdata  = req_wdata;
            mem_read   = req_read;
            mem_write  = req_write;
            mem_func3  = req_func3;
            load_data  = req_read ? mem_rdata : 32'h0;
            load_valid = req_read;
          end
        end
      end
      SPLIT: begin
        mem_addr  = addr_p1 + 32'(cnt);
        mem_wdata = {24'h0, wdata_p1[{cnt, 3'b000} +: 8]};
        mem_read  = read_p1;
        mem_write = write_p1;
        mem_func3 = read_p1 ? 3'b100 : 3'b000;
        stall     = 1'b1;
        if (last_byte) state_nxt = DONE;
      end
      DONE: begin
        // Request inputs are still held by the frozen pipeline; ignore them.
        load_valid = read_p1;
        load_data  = read_p1 ? extend_load(func3_p1, asm_word) : 32'h0;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset forces every output low immediately, even mid-sequence.
    if (!reset) begin
      mem_addr   = 32'h0;
      mem_wdata  = 32'h0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_func3  = 3'b000;
      load_data  = 32'h0;
      load_valid = 1'b0;
      stall      = 1'b0;
      illegal    = 1'b0;
    end
  end

  // Stage boundary: control state, byte counter and load assembly register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      asm_word <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        cnt      <= 2'd0;
        asm_word <= '0;
      end else if (state == SPLIT) begin
        cnt <= cnt + 2'd1;
        if (read_p1) asm_word[{cnt, 3'b000} +: 8] <= mem_rdata[7:0];
      end
    end
  end

  // Stage boundary: captured request held for the split sequence
  always_ff @(posedge clk) begin
    if (start) begin
      addr_p1  <= req_addr;
      wdata_p1 <= req_wdata;
      func3_p1 <= req_func3;
      read_p1  <= req_read;
      write_p1 <= req_write;
    end
  end

endmodule

// File: tb/tb_misalign_access_unit.sv
module tb_misalign_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_read, req_write;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_read, mem_write;
  logic [2:0]  mem_func3;
  logic [31:0] load_data;
  logic        load_valid, stall, illegal;

  always #5 clk = ~clk;

  misalign_access_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_func3(mem_func3),
    .load_data(load_data), .load_valid(load_valid),
    .stall(stall), .illegal(illegal)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [2:0]  f;
    logic        r;
    logic        w;
    logic [31:0] d;
  } acc_t;

  acc_t        accq[$];
  logic [31:0] ldq[$];
  bit          illq[$];

  // Byte memory model indexed by the low address byte (wraps at 256).
  logic [7:0] mem [256];
  logic       mem_init = 1'b1;
  logic [7:0] ra0, ra1, ra2, ra3;

  always_comb begin
    ra0 = mem_addr[7:0];
    ra1 = ra0 + 8'd1;
    ra2 = ra0 + 8'd2;
    ra3 = ra0 + 8'd3;
    mem_rdata = 32'h0;
    if (mem_read) begin
      case (mem_func3)
        3'b000:  mem_rdata = {{24{mem[ra0][7]}}, mem[ra0]};
        3'b100:  mem_rdata = {24'h0, mem[ra0]};
        3'b001:  mem_rdata = {{16{mem[ra1][7]}}, mem[ra1], mem[ra0]};
        3'b101:  mem_rdata = {16'h0, mem[ra1], mem[ra0]};
        default: mem_rdata = {mem[ra3], mem[ra2], mem[ra1], mem[ra0]};
      endcase
    end
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h10] <= 8'h44; mem[8'h11] <= 8'h33; mem[8'h12] <= 8'h22; mem[8'h13] <= 8'h11;
      mem[8'h05] <= 8'h80; mem[8'h06] <= 8'hFF;
      mem[8'hFF] <= 8'h34; mem[8'h00] <= 8'h92;
      mem[8'h31] <= 8'h01; mem[8'h32] <= 8'h02; mem[8'h33] <= 8'h03; mem[8'h34] <= 8'h84;
    end else if (reset && mem_write) begin
      mem[ra0] <= mem_wdata[7:0];
      if (mem_func3[1:0] != 2'b00) mem[ra1] <= mem_wdata[15:8];
      if (mem_func3[1:0] == 2'b10) begin
        mem[ra2] <= mem_wdata[23:16];
        mem[ra3] <= mem_wdata[31:24];
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic acc_t mk(input logic [31:0] a, input logic [2:0] f,
                              input logic r, input logic w, input logic [31:0] d);
    mk = '{a: a, f: f, r: r, w: w, d: d};
  endfunction

  function automatic logic [103:0] outs();
    outs = {mem_addr, mem_wdata, mem_read, mem_write, mem_func3,
            load_data, load_valid, stall, illegal};
  endfunction

  // Monitor: pops expectations whenever the DUT presents an output.
  acc_t        mon_e;
  acc_t        mon_a;
  logic [31:0] mon_ld;
  always @(negedge clk) begin
    if (reset) begin
      if (mem_read || mem_write) begin
        mon_a = mk(mem_addr, mem_func3, mem_read, mem_write, mem_write ? mem_wdata : 32'h0);
        if (accq.size() == 0) begin
          fail_now("unexpected_access");
        end else begin
          mon_e = accq.pop_front();
          chk("access", 128'(mon_a), 128'(mon_e));
        end
      end
      if (load_valid) begin
        if (ldq.size() == 0) begin
          fail_now("unexpected_load_valid");
        end else begin
          mon_ld = ldq.pop_front();
          chk("load_data", 128'(load_data), 128'(mon_ld));
        end
      end
      if (illegal) begin
        if (illq.size() == 0) fail_now("unexpected_illegal");
        else chk("illegal", 128'(illegal), 128'(illq.pop_front()));
      end
    end
  end

  // Drive one request, hold it while stalled, and check the stall length.
  task automatic run(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input int exp_stall);
    int  nst;
    bit  done;
    nst  = 0;
    done = 1'b0;
    req_valid = 1'b1; req_read = rd; req_write = wr;
    req_func3 = f3;   req_addr = a;  req_wdata = wd;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (stall) begin
        nst++;
        @(posedge clk); #1;
      end else begin
        done = 1'b1;
      end
    end
    if (!done) fail_now("stall_timeout");
    chk("stall_cycles", 128'(nst), 128'(exp_stall));
    @(posedge clk); #1;
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    reset = 1'b0;
    req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
    req_func3 = 3'b010; req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF;
    #12;
    chk("reset_outputs", 128'(outs()), 128'h0);
    mem_init = 1'b0;
    req_valid = 1'b0; req_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Aligned lw 0x10
    accq.push_back(mk(32'h10, 3'b010, 1, 0, 0)); ldq.push_back(32'h1122_3344);
    run(1, 0, 3'b010, 32'h10, 0, 0);

    // Misaligned lh 0x05
    accq.push_back(mk(32'h05, 3'b100, 1, 0, 0));
    accq.push_back(mk(32'h06, 3'b100, 1, 0, 0));
    ldq.push_back(32'hFFFF_FF80);
    run(1, 0, 3'b001, 32'h05, 0, 3);

    // Misaligned sw 0xAABBCCDD at 0x03, then lw 0x04
    accq.push_back(mk(32'h03, 3'b000, 0, 1, 32'hDD));
    accq.push_back(mk(32'h04, 3'b000, 0, 1, 32'hCC));
    accq.push_back(mk(32'h05, 3'b000, 0, 1, 32'hBB));
    accq.push_back(mk(32'h06, 3'b000, 0, 1, 32'hAA));
    run(0, 1, 3'b010, 32'h03, 32'hAABB_CCDD, 5);
    accq.push_back(mk(32'h04, 3'b010, 1, 0, 0)); ldq.push_back(32'h00AA_BBCC);
    run(1, 0, 3'b010, 32'h04, 0, 0);

    // Wrap-around lhu 0xFFFFFFFF
    accq.push_back(mk(32'hFFFF_FFFF, 3'b100, 1, 0, 0));
    accq.push_back(mk(32'h0000_0000, 3'b100, 1, 0, 0));
    ldq.push_back(32'h0000_9234);
    run(1, 0, 3'b101, 32'hFFFF_FFFF, 0, 3);

    // Misaligned lw 0x31
    for (int i = 0; i < 4; i++) accq.push_back(mk(32'h31 + 32'(i), 3'b100, 1, 0, 0));
    ldq.push_back(32'h8403_0201);
    run(1, 0, 3'b010, 32'h31, 0, 5);

    // Misaligned sh 0x41, then lw 0x40
    accq.push_back(mk(32'h41, 3'b000, 0, 1, 32'h78));
    accq.push_back(mk(32'h42, 3'b000, 0, 1, 32'h56));
    run(0, 1, 3'b001, 32'h41, 32'h1234_5678, 3);
    accq.push_back(mk(32'h40, 3'b010, 1, 0, 0)); ldq.push_back(32'h0056_7800);
    run(1, 0, 3'b010, 32'h40, 0, 0);

    // Illegal requests
    illq.push_back(1'b1);
    run(1, 0, 3'b011, 32'h10, 0, 0);
    illq.push_back(1'b1);
    run(1, 1, 3'b010, 32'h10, 32'h5555_5555, 0);

    // Idle: req_valid low with other request fields active
    req_read = 1'b1; req_func3 = 3'b010; req_addr = 32'h10;
    #1;
    chk("idle_outputs", 128'(outs()), 128'h0);
    req_read = 1'b0;

    // Aligned sb / lbu / lh
    accq.push_back(mk(32'h50, 3'b000, 0, 1, 32'h1234_56EF));
    run(0, 1, 3'b000, 32'h50, 32'h1234_56EF, 0);
    accq.push_back(mk(32'h50, 3'b100, 1, 0, 0)); ldq.push_back(32'h0000_00EF);
    run(1, 0, 3'b100, 32'h50, 0, 0);
    accq.push_back(mk(32'h06, 3'b001, 1, 0, 0)); ldq.push_back(32'h0000_00AA);
    run(1, 0, 3'b001, 32'h06, 0, 0);

    // Reset during the 2nd SPLIT cycle of a misaligned sw
    @(posedge clk); #1;
    accq.push_back(mk(32'h21, 3'b000, 0, 1, 32'h44));
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1;
    req_func3 = 3'b010; req_addr = 32'h21; req_wdata = 32'h1122_3344;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("reset_midop_outputs", 128'(outs()), 128'h0);
    req_valid = 1'b0; req_write = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    accq.push_back(mk(32'h21, 3'b000, 1, 0, 0)); ldq.push_back(32'h0000_0044);
    run(1, 0, 3'b000, 32'h21, 0, 0);
    accq.push_back(mk(32'h22, 3'b000, 1, 0, 0)); ldq.push_back(32'h0000_0000);
    run(1, 0, 3'b000, 32'h22, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("access_queue_drained", 128'(accq.size()), 128'h0);
    chk("load_queue_drained", 128'(ldq.size()), 128'h0);
    chk("illegal_queue_drained", 128'(illq.size()), 128'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/misalign_access_unit.md
MISALIGN_ACCESS_UNIT -- requirements
Module: misalign_access_unit

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single rising-edge clock.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port req_valid, input, 1 bit: the MEM stage presents an access this cycle.
REQ-004 The block SHALL have the ports req_read and req_write, input, 1 bit each: load request and store request.
REQ-005 The block SHALL have the port req_func3, input, 3 bits: RISC-V load/store funct3.
REQ-006 The block SHALL have the ports req_addr and req_wdata, input, 32 bits each: byte address and store data.
REQ-007 The block SHALL have the port mem_rdata, input, 32 bits: combinational read data from the data memory, valid in the same cycle.
REQ-008 The block SHALL have the ports mem_addr and mem_wdata, output, 32 bits each: address and write data to the data memory.
REQ-009 The block SHALL have the ports mem_read, mem_write and mem_func3 (3 bits), outputs: controls to the data memory.
REQ-010 The block SHALL have the ports load_data (output, 32 bits) and load_valid (output, 1 bit): the final load result to the MEM/WB register.
REQ-011 The block SHALL have the ports stall (output, 1 bit: freeze the pipeline) and illegal (output, 1 bit: one-cycle pulse flagging an unsupported request).

Function
REQ-012 The block SHALL classify an access as aligned for these cases: byte (000/100) at any address; half (001/101) when addr[0]=0; word (010) when addr[1:0]=0.
REQ-013 The block SHALL treat func3 011, 110 and 111, and req_read&req_write both high, as illegal: no memory access, illegal=1 for that cycle, stall=0.
REQ-014 In the IDLE state, for an aligned valid request, the block SHALL pass through combinationally: mem_* = req_*, load_data = mem_rdata, load_valid = req_read, stall = 0. The latency is zero cycles.
REQ-015 In IDLE, for a misaligned valid request, the block SHALL issue no access (mem_read=mem_write=0), assert stall=1, capture addr/wdata/func3/read-write, clear the byte counter, and go to SPLIT.
REQ-016 The block SHALL use N = 2 for a half access and N = 4 for a word access.
REQ-017 In SPLIT, each cycle the block SHALL issue one byte access with these values: mem_addr = base + cnt (mod 2^32); mem_func3 = 000 for a store or 100 for a load; mem_wdata[7:0] = wdata[8*cnt+7 : 8*cnt], with upper bits 0.
REQ-018 In SPLIT, for a load, the block SHALL latch mem_rdata[7:0] into byte cnt of the assembly register at the clock edge.
REQ-019 In SPLIT, the block SHALL hold stall=1 and increment cnt by 1; when cnt = N-1 it SHALL go to DONE.
REQ-020 In DONE, the block SHALL drive stall=0 and issue no memory access, and it SHALL ignore req_* for that cycle (the held request must not retrigger).
REQ-021 In DONE, for a load, load_valid SHALL be 1 and load_data SHALL be: 001 = sign-extend assembly[15:0]; 101 = zero-extend assembly[15:0]; 010 = assembly[31:0]. For a store, load_valid SHALL be 0.
REQ-022 From DONE, the block SHALL always return to IDLE on the next cycle.
REQ-023 The total occupancy for a misaligned half access SHALL be 4 cycles (stall high for 3). For a misaligned word access it SHALL be 6 cycles (stall high for 5).
REQ-024 When req_valid=0 in IDLE, all mem_* controls, load_valid, illegal and stall SHALL be 0.
REQ-025 The upper assembly bytes SHALL be cleared on entry to SPLIT, so no stale data leaks.

Reset
REQ-026 While reset=0, regardless of clk, the block SHALL set state=IDLE, cnt=0 and the assembly register to 0.
REQ-027 While reset=0, all outputs SHALL be 0: mem_addr, mem_wdata, mem_read, mem_write, mem_func3, load_data, load_valid, stall and illegal.
REQ-028 If reset is asserted mid-SPLIT, the block SHALL abort immediately. Bytes already written stay in memory (no rollback), and no load_valid is produced.
REQ-029 After reset deasserts, the block SHALL accept a new request on the first rising edge.

Verification
REQ-030 Aligned load: lw at 0x10, with memory bytes 0x10..0x13 = 44 33 22 11 -> same cycle mem_func3=010, load_data=0x11223344, stall=0.
REQ-031 Misaligned load: lh at 0x05, with bytes 0x05 = 0x80 and 0x06 = 0xFF -> stall for 3 cycles; byte reads at 0x05 and 0x06 with func3=100; in DONE, load_data=0xFFFFFF80 and load_valid=1.
REQ-032 Misaligned store: sw 0xAABBCCDD at 0x03 -> stall for 5 cycles; byte writes DD, CC, BB, AA at 0x03..0x06; the following lw at 0x04 returns 0x00AABBCC, given memory initialised to 0.
REQ-033 Wrap-around: lhu at 0xFFFFFFFF -> byte accesses at 0xFFFFFFFF then 0x00000000, and load_data is zero-extended.
REQ-034 Illegal: func3=011 with req_read=1 -> illegal=1 for one cycle, mem_read=0, stall=0.
REQ-035 Reset mid-op: assert reset during the 2nd SPLIT cycle of a misaligned sw -> outputs go to 0 immediately; after release the state is IDLE and the next aligned lb completes in one cycle.
